exponent_accelerator_hex_writer: RTL and testbench

//  Avalon-MM master (initiator) that drives the 7-segment HEX output-port slaves. On start it latches
//  a hex value, encodes each nibble to a 7-seg pattern and writes one pattern per HEX slave, in order.

---
 rtl/exponent_accelerator_hex_pkg.sv | 50 +++++
 rtl/exponent_accelerator_hex_7seg.sv | 19 +
 rtl/exponent_accelerator_hex_writer.sv | 145 ++++++++++++++
 tb/tb_exponent_accelerator_hex_writer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exponent_accelerator_hex_pkg.sv
// Shared types and 7-segment encoding for the HEX writer.
// Patterns are active-high with seg[0]=a .. seg[6]=g.
package exponent_accelerator_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/exponent_accelerator_hex_7seg.sv
// Combinational nibble-to-7-segment encoder with blanking and selectable polarity.
module exponent_accelerator_hex_7seg
  import exponent_accelerator_hex_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_raw;

  always_comb begin
    seg_raw = blank ? SEG_BLANK : hex_to_seg(nibble);
    seg     = ACTIVE_LOW ? ~seg_raw : seg_raw;
  end

endmodule

// File: rtl/exponent_accelerator_hex_writer.sv
// Avalon-MM write master: latches a hex value on start and writes one
// 7-segment pattern per HEX PIO slave, digit 0 first, with no gaps between writes.
module exponent_accelerator_hex_writer
  import exponent_accelerator_hex_pkg::*;
#(
  parameter int                NUM_DIGITS    = 6,
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                ADDR_STRIDE   = 16,
  parameter bit                ACTIVE_LOW    = 1'b1,
  parameter bit                BLANK_LEADING = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  input  logic                    avm_waitrequest
);

  localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int                VAL_W    = 4 * NUM_DIGITS;
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [6:0]              seg_q, seg_d;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [VAL_W-1:0]        sel_src;
  int                      sel_i;
  logic [3:0]              sel_nibble;
  logic                    sel_blank;
  logic [6:0]              sel_seg;

  // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_mask = '0;
    if (BLANK_LEADING) begin
      for (int i = 1; i < NUM_DIGITS; i++) begin
        blank_mask[i] = ((value >> (4 * i)) == '0);
      end
    end
  end

  // The encoder always looks one digit ahead: digit 0 of the live input while
  // idle, otherwise the latched digit that follows the one on the bus.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_src    = value;
    sel_i      = 0;
    sel_nibble = '0;
    sel_blank  = 1'b0;
    if (state_q == WRITE) begin
      sel_src = value_q;
      sel_i   = (idx_q == LAST_IDX) ? 0 : int'(idx_q) + 1;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == sel_i) begin
        sel_nibble = sel_src[4*i +: 4];
        sel_blank  = (state_q == WRITE) && blank_q[i];
      end
    end
  end

  exponent_accelerator_hex_7seg #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_7seg (
    .nibble (sel_nibble),
    .blank  (sel_blank),
    .seg    (sel_seg)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      value_q <= '0;
      blank_q <= '0;
      addr_q  <= BASE_ADDR;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      blank_q <= blank_d;
      addr_q  <= addr_d;
      seg_q   <= seg_d;
    end
  end

  // Address and data only advance on acceptance, so a stalled write holds the bus steady.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    blank_d = blank_q;
    addr_d  = addr_q;
    seg_d   = seg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          idx_d   = '0;
          value_d = value;
          blank_d = blank_mask;
          addr_d  = BASE_ADDR;
          seg_d   = sel_seg;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + STRIDE;
            seg_d  = sel_seg;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    avm_write     = (state_q == WRITE);
    avm_address   = addr_q;
    avm_writedata = {25'b0, seg_q};
  end

endmodule

// File: tb/tb_exponent_accelerator_hex_writer.sv
// Scoreboard bench for the HEX writer: three instances cover the default build,
// leading-zero blanking, and a 4-digit active-high build.
module tb_exponent_accelerator_hex_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        start_a, busy_a, done_a, write_a, wait_a;
  logic [23:0] value_a;
  logic [15:0] addr_a;
  logic [31:0] wdata_a;

  logic        start_b, busy_b, done_b, write_b, wait_b;
  logic [23:0] value_b;
  logic [15:0] addr_b;
  logic [31:0] wdata_b;

  logic        start_c, busy_c, done_c, write_c, wait_c;
  logic [15:0] value_c;
  logic [15:0] addr_c;
  logic [31:0] wdata_c;

  exponent_accelerator_hex_writer u_dut_a (
    .clk (clk), .reset_n (reset_n), .start (start_a), .value (value_a),
    .busy (busy_a), .done (done_a), .avm_address (addr_a), .avm_write (write_a),
    .avm_writedata (wdata_a), .avm_waitrequest (wait_a)
  );

  exponent_accelerator_hex_writer #(.BLANK_LEADING(1'b1)) u_dut_b (
    .clk (clk), .reset_n (reset_n), .start (start_b), .value (value_b),
    .busy (busy_b), .done (done_b), .avm_address (addr_b), .avm_write (write_b),
    .avm_writedata (wdata_b), .avm_waitrequest (wait_b)
  );

  exponent_accelerator_hex_writer #(.NUM_DIGITS(4), .ACTIVE_LOW(1'b0)) u_dut_c (
    .clk (clk), .reset_n (reset_n), .start (start_c), .value (value_c),
    .busy (busy_c), .done (done_c), .avm_address (addr_c), .avm_write (write_c),
    .avm_writedata (wdata_c), .avm_waitrequest (wait_c)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [31:0] dt;
    logic        b;
    logic        dn;
  } snap_t;

  wr_t exp_q[$];

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // d=0: active-low, d=1: active-low with leading blanking, d=2: active-high 4-digit
  function automatic logic [31:0] exp_data(input int d, input logic [23:0] v, input int i);
    logic [3:0] n;
    logic [6:0] s;
    logic       blank;
    n     = v[4*i +: 4];
    blank = (d == 1) && (i != 0) && ((v >> (4 * i)) == 24'h0);
    s     = blank ? 7'h00 : ref_seg(n);
    if (d != 2) s = ~s;
    return {25'b0, s};
  endfunction

  task automatic set_start(input int d, input logic s, input logic [23:0] v);
    case (d)
      0: begin start_a = s; value_a = v; end
      1: begin start_b = s; value_b = v; end
      default: begin start_c = s; value_c = v[15:0]; end
    endcase
  endtask

  task automatic set_wait(input int d, input logic w);
    case (d)
      0: wait_a = w;
      1: wait_b = w;
      default: wait_c = w;
    endcase
  endtask

  function automatic snap_t snap(input int d);
    case (d)
      0: return '{w: write_a, a: addr_a, dt: wdata_a, b: busy_a, dn: done_a};
      1: return '{w: write_b, a: addr_b, dt: wdata_b, b: busy_b, dn: done_b};
      default: return '{w: write_c, a: addr_c, dt: wdata_c, b: busy_c, dn: done_c};
    endcase
  endfunction

  // Runs one full transfer; entered and left just after a rising edge.
  task automatic transfer(input int d, input logic [23:0] v, input int stall_digit,
                          input int stall_len, input bit repulse, input string name);
    int    nd;
    int    writes;
    int    stalls;
    bit    seen_done;
    bit    stall;
    snap_t s;
    wr_t   e;
    nd = (d == 2) ? 4 : 6;
    for (int i = 0; i < nd; i++) begin
      e.addr = 16'(i * 16);
      e.data = exp_data(d, v, i);
      exp_q.push_back(e);
    end
    set_start(d, 1'b1, v);
    @(posedge clk); #1;
    set_start(d, 1'b0, ~v);
    writes    = 0;
    stalls    = 0;
    seen_done = 1'b0;
    for (int k = 1; k <= 40 && !seen_done; k++) begin
      stall = (writes == stall_digit) && (stalls < stall_len);
      if (stall) stalls++;
      set_wait(d, stall);
      if (repulse && k == 2) set_start(d, 1'b1, v ^ 24'h5A5A5A);
      if (repulse && k == 3) set_start(d, 1'b0, ~v);
      @(negedge clk);
      s = snap(d);
      total++;
      if (s.b !== 1'b1) begin
        bad++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, k, s.b);
      end
      if (s.dn === 1'b1) begin
        seen_done = 1'b1;
        total++;
        if (k != nd + 1 + stall_len || writes != nd || s.w !== 1'b0) begin
          bad++;
          $display("FAIL %s done: cycle=%0d writes=%0d write=%b want cycle=%0d writes=%0d write=0",
                   name, k, writes, s.w, nd + 1 + stall_len, nd);
        end
      end else if (s.w === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra write: addr=%h data=%h", name, s.a, s.dt);
        end else begin
          e = exp_q[0];
          if (s.a !== e.addr || s.dt !== e.data) begin
            bad++;
            $display("FAIL %s write %0d: addr=%h data=%h want addr=%h data=%h",
                     name, writes, s.a, s.dt, e.addr, e.data);
          end
          if (!stall) begin
            void'(exp_q.pop_front());
            writes++;
          end
        end
      end else begin
        total++;
        bad++;
        $display("FAIL %s gap cycle %0d: write=%b done=%b want write or done", name, k, s.w, s.dn);
      end
      @(posedge clk); #1;
    end
    set_wait(d, 1'b0);
    if (!seen_done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: done not seen, got writes=%0d want %0d", name, writes, nd);
    end
    exp_q.delete();
    @(negedge clk);
    s = snap(d);
    total++;
    if (s.b !== 1'b0 || s.dn !== 1'b0 || s.w !== 1'b0) begin
      bad++;
      $display("FAIL %s after done: busy=%b done=%b write=%b want 0 0 0", name, s.b, s.dn, s.w);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input int d, input string name);
    snap_t s;
    s = snap(d);
    total++;
    if (s.b !== 1'b0 || s.dn !== 1'b0 || s.w !== 1'b0 || s.a !== 16'h0 || s.dt !== 32'h0) begin
      bad++;
      $display("FAIL %s dut%0d: busy=%b done=%b write=%b addr=%h data=%h want all 0",
               name, d, s.b, s.dn, s.w, s.a, s.dt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_start(d, 1'b0, 24'h0);
      set_wait(d, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle(d, "reset");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    transfer(0, 24'h12AB0F, 0, 0, 1'b0, "basic");
    transfer(0, 24'h987654, 0, 0, 1'b0, "basic2");
  endtask

  task automatic test_stall();
    transfer(0, 24'h12AB0F, 2, 3, 1'b0, "stall");
    transfer(0, 24'hCDEF30, 0, 1, 1'b0, "stall_first");
    transfer(0, 24'h456789, 5, 2, 1'b0, "stall_last");
  endtask

  task automatic test_blank_leading();
    transfer(1, 24'h000005, 0, 0, 1'b0, "blank5");
    transfer(1, 24'h000000, 0, 0, 1'b0, "blank0");
    transfer(1, 24'h00A030, 0, 0, 1'b0, "blank_mid");
  endtask

  task automatic test_restart_ignored();
    transfer(0, 24'h345678, 0, 0, 1'b1, "restart");
  endtask

  task automatic test_reset_mid();
    int    accepts;
    snap_t s;
    accepts = 0;
    set_start(0, 1'b1, 24'h12AB0F);
    @(posedge clk); #1;
    set_start(0, 1'b0, 24'h0);
    for (int k = 0; k < 20 && accepts < 3; k++) begin
      @(negedge clk);
      s = snap(0);
      if (s.w === 1'b1) accepts++;
      @(posedge clk); #1;
    end
    total++;
    if (accepts != 3) begin
      bad++;
      $display("FAIL reset_mid setup: accepts=%0d want 3", accepts);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle(0, "reset_mid");
    @(posedge clk); #1;
    transfer(0, 24'hFEDCBA, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_four_digit();
    transfer(2, 24'h008C3E, 0, 0, 1'b0, "four_digit");
    transfer(2, 24'h001F07, 3, 2, 1'b0, "four_stall");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      transfer(0, 24'($urandom), $urandom_range(0, 5), $urandom_range(0, 2), 1'b0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_blank_leading();
    test_restart_ignored();
    test_reset_mid();
    test_four_digit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
